// File: rtl/matrix_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : matrix_seq_if
// Description : Decode-side request and memory/matrix-RF side bundle of the
//               matrix tile sequencer.
// Revision    : 1.0
// ============================================================================
interface matrix_seq_if #(
  parameter int ROWS   = 4,
  parameter int ADDR_W = 32,
  parameter int RIDX_W = $clog2(ROWS)
);
  logic              start;
  logic [1:0]        op;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] stride;
  logic              flush;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [RIDX_W-1:0] row_idx;
  logic              mrow_we;
  logic              mopa_en;
  logic              stall;
  logic              busy;
  logic              done;

  // Driver side: decode, memory and register-file models.
  modport master (
    output start, op, base, stride, flush, mem_ack,
    input  mem_req, mem_we, mem_addr, row_idx, mrow_we, mopa_en, stall, busy, done
  );

  modport slave (
    input  start, op, base, stride, flush, mem_ack,
    output mem_req, mem_we, mem_addr, row_idx, mrow_we, mopa_en, stall, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/matrix_seq.sv
`default_nettype none
// ============================================================================
// Module      : matrix_seq
// Description : Multi-cycle sequencer walking the rows of a matrix tile for
//               tile load, tile store and outer-product accumulate.
// Revision    : 1.0
// ============================================================================
module matrix_seq #(
  parameter int ROWS   = 4,
  parameter int ADDR_W = 32,
  parameter int RIDX_W = $clog2(ROWS)
) (
  input  logic         clk,
  input  logic         rst,
  matrix_seq_if.slave  bus
);

  localparam logic [1:0]        c_OP_STORE = 2'b01;
  localparam logic [1:0]        c_OP_MOPA  = 2'b10;
  localparam logic [1:0]        c_OP_RSVD  = 2'b11;
  localparam logic [1:0]        c_OP_LOAD  = 2'b00;
  localparam logic [RIDX_W-1:0] c_LAST_ROW = RIDX_W'(ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEM  = 2'd1,
    S_MOPA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  logic [RIDX_W-1:0]  r_row;
  logic [ADDR_W-1:0]  r_addr;
  logic [1:0]         r_op;
  logic [ADDR_W-1:0]  r_stride;

  state_t             w_state_nxt;
  logic [RIDX_W-1:0]  w_row_nxt;
  logic [ADDR_W-1:0]  w_addr_nxt;
  logic [1:0]         w_op_nxt;
  logic [ADDR_W-1:0]  w_stride_nxt;
  logic               w_accept;
  logic               w_in_mem;
  logic               w_in_mopa;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_row    <= '0;
      r_addr   <= '0;
      r_op     <= '0;
      r_stride <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_row    <= w_row_nxt;
      r_addr   <= w_addr_nxt;
      r_op     <= w_op_nxt;
      r_stride <= w_stride_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_row_nxt    = r_row;
    w_addr_nxt   = r_addr;
    w_op_nxt     = r_op;
    w_stride_nxt = r_stride;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start && (bus.op != c_OP_RSVD) && !bus.flush) begin
          w_accept  = 1'b1;
          w_op_nxt  = bus.op;
          w_row_nxt = '0;
          if (bus.op == c_OP_MOPA) begin
            w_state_nxt = S_MOPA;
          end else begin
            w_state_nxt  = S_MEM;
            w_addr_nxt   = bus.base;
            w_stride_nxt = bus.stride;
          end
        end
      end
      S_MEM: begin
        if (bus.mem_ack) begin
          w_addr_nxt = r_addr + r_stride;
          w_row_nxt  = r_row + 1'b1;
          if (r_row == c_LAST_ROW) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_MOPA: begin
        w_row_nxt = r_row + 1'b1;
        if (r_row == c_LAST_ROW) begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // Abort overrides any progress made this cycle, including a late ack.
    if (bus.flush) begin
      w_state_nxt = S_IDLE;
      w_row_nxt   = '0;
      w_addr_nxt  = '0;
    end
  end

  assign w_in_mem  = (r_state == S_MEM);
  assign w_in_mopa = (r_state == S_MOPA);

  assign bus.mem_req  = w_in_mem && !bus.flush;
  assign bus.mem_we   = w_in_mem && (r_op == c_OP_STORE);
  assign bus.mem_addr = w_in_mem ? r_addr : '0;
  assign bus.row_idx  = (w_in_mem || w_in_mopa) ? r_row : '0;
  assign bus.mrow_we  = w_in_mem && (r_op == c_OP_LOAD) && bus.mem_ack && !bus.flush;
  assign bus.mopa_en  = w_in_mopa && !bus.flush;
  assign bus.busy     = w_in_mem || w_in_mopa;
  assign bus.done     = (r_state == S_DONE);
  // The accepting cycle stalls combinationally; reset masks a start seen during reset.
  assign bus.stall    = !rst && (w_accept || w_in_mem || w_in_mopa);

endmodule
`default_nettype wire

// File: doc/matrix_seq.md
# matrix_seq

Multi-cycle sequencer for the matrix extension's tile operations. When decode issues a matrix tile load (MtypeL), tile store (MtypeS) or outer-product accumulate (MtypePA), this block:
- stalls the integer pipeline;
- walks the ROWS rows of the tile, issuing one memory request per row for load/store, or one accumulate step per row for MOPA;
- releases the pipeline with a one-cycle done pulse.

It sits between the decode/control stage and the data-memory port and matrix register file.

## Interface
Parameters:
- ROWS, 4: rows per matrix tile; power of two, ≥2.
- ADDR_W, 32: memory address width.
- RIDX_W, $clog2(ROWS): row-index width.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  one-cycle request from decode.
- op  in  2  operation code: 00 load, 01 store, 10 mopa, 11 reserved.
- base  in  ADDR_W  row-0 byte address; sampled with start.
- stride  in  ADDR_W  byte distance between rows; sampled with start.
- flush  in  1  abort the current sequence (branch/exception).
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = store request, 0 = load request.
- mem_addr  out  ADDR_W  current row address.
- mem_ack  in  1  memory accepted/completed the current row this cycle.
- row_idx  out  RIDX_W  current row number.
- mrow_we  out  1  write the loaded row into the matrix register file at row_idx.
- mopa_en  out  1  perform one MOPA accumulate step on row_idx.
- stall  out  1  freeze the upstream pipeline.
- busy  out  1  state is MEM or MOPA.
- done  out  1  one-cycle completion pulse.

## Operation
States: IDLE, MEM, MOPA, DONE.

Reset (async, rst=1):
- state=IDLE.
- Row counter, address register and latched op/stride cleared to 0.
- Every output 0.

IDLE:
- start=1 with op∈{00,01}: latch op, stride; addr←base; row←0; next state MEM.
- start=1 with op=10: latch op; row←0; next state MOPA.
- op=11: ignored; state stays IDLE; no stall, no done.

MEM:
- mem_req=1.
- mem_we=1 when the latched op is 01, otherwise 0.
- mem_addr=addr; row_idx=row.
- Request fields are held stable until mem_ack.
- On mem_ack:
  - load only: mrow_we=1 in the same cycle.
  - addr←addr+stride, modulo 2^ADDR_W (wraps silently).
  - row←row+1.
  - If row==ROWS-1 at the ack, next state is DONE.
- mem_req stays high across consecutive rows, so back-to-back acks give one row per cycle.

MOPA:
- mopa_en=1 every cycle; row_idx=row; row increments each cycle.
- After the cycle with row==ROWS-1, next state is DONE.

DONE:
- done=1 and stall=0 for exactly one cycle, then IDLE.
- A start in the DONE cycle is ignored; decode must re-present it.

stall:
- 1 in the IDLE cycle in which a valid start (op≠11) is accepted, combinationally, so the issuing instruction freezes the same cycle.
- 1 throughout MEM and MOPA.
- 0 otherwise.

busy = state∈{MEM, MOPA}. start while busy is ignored.

flush:
- In any state: next state IDLE; counters cleared; no done pulse.
- Combinational effect in the flush cycle: mem_req, mrow_we and mopa_en are forced to 0.
- flush together with start in IDLE: flush wins; the start is dropped and stall=0.
- mem_ack arriving in a flush cycle is ignored; no row is written.

mrow_we and mopa_en are never asserted outside MEM and MOPA respectively.

## Timing
- Accepted start at cycle T (stall=1 at T).
- Load/store with mem_ack tied high:
  - MEM at T+1..T+ROWS, rows 0..ROWS-1.
  - done at T+ROWS+1.
  - Pipeline resumes at T+ROWS+1.
- Each cycle without mem_ack adds one cycle.
- MOPA: mopa_en at T+1..T+ROWS; done at T+ROWS+1.
- Address register updates on the ack edge; the new mem_addr is visible the cycle after the ack.
- All outputs except stall, and the flush gating of mem_req/mrow_we/mopa_en, are functions of registered state. The mrow_we qualification by mem_ack is the only other combinational path.

## Test plan
- Load, ROWS=4, base=0x1000, stride=0x10, mem_ack always 1:
  - mem_addr 0x1000/0x1010/0x1020/0x1030 on consecutive cycles;
  - mrow_we=1 with row_idx 0..3;
  - done exactly at T+5; stall high T..T+4.
- Store, base=0x2000, stride=0x20, mem_ack low for 2 cycles on row 1:
  - mem_we=1 throughout;
  - mem_addr holds 0x2020 for 3 cycles;
  - mrow_we never asserted;
  - done at T+7.
- MOPA start:
  - mopa_en=1 for exactly 4 cycles with row_idx 0,1,2,3;
  - mem_req stays 0; done at T+5.
- flush during MEM row 2, with mem_ack=1 the same cycle:
  - no mrow_we that cycle; state IDLE next cycle;
  - done never pulses; stall drops the next cycle.
- Wrap-around and rejection:
  - base=0xFFFF_FFF0, stride=0x10: addresses 0xFFFF_FFF0, 0x0, 0x10, 0x20.
  - op=11 start: no stall, no done.
  - start while busy: ignored.
- rst asserted mid-MEM (asynchronous, between edges): all outputs 0 immediately; IDLE after release.
